// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU front end: fetch FSM states, branch-select
// encodings and default widths/reset address.
package mcu_pkg;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 16;
  localparam logic [7:0] RESET_PC_DEF = 8'h00;

  localparam logic [1:0] BS_SEQ = 2'b00;
  localparam logic [1:0] BS_JMP = 2'b10;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction register and a 3-state
// FSM that primes after reset and inserts one bubble on every taken redirect.
module fetch_unit
  import mcu_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int AW = AW_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [1:0]    BS,
  input  logic [AW-1:0] pc_next,
  input  logic [IW-1:0] imem_data,
  output logic [AW-1:0] imem_addr,
  output logic [AW-1:0] pc_value,
  output logic [AW-1:0] PC_minus1,
  output logic [IW-1:0] ir_out,
  output logic          ir_valid
);

  state_t        state, state_nxt;
  logic [AW-1:0] pc_p0, pc_nxt;
  logic [AW-1:0] pcm1_p1, pcm1_nxt;
  logic [IW-1:0] ir_p1, ir_nxt;
  logic          vld_p1, vld_nxt;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_p0;
    pcm1_nxt  = pcm1_p1;
    ir_nxt    = ir_p1;
    vld_nxt   = vld_p1;
    if (!stall) begin
      // Every unstalled edge captures the word at the current PC; only the
      // valid flag decides whether decode will act on it.
      ir_nxt   = imem_data;
      pcm1_nxt = pc_p0;
      case (state)
        PRIME, FLUSH: begin
          pc_nxt    = pc_p0 + AW'(1);
          vld_nxt   = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          if (vld_p1 && (BS != BS_SEQ)) begin
            pc_nxt    = pc_next;
            vld_nxt   = 1'b0;
            state_nxt = FLUSH;
          end else begin
            pc_nxt    = pc_p0 + AW'(1);
            vld_nxt   = 1'b1;
          end
        end
        default: begin
          vld_nxt   = 1'b0;
          state_nxt = PRIME;
        end
      endcase
    end
  end

  // Stage p0 -> p1 register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PRIME;
      pc_p0   <= RESET_PC;
      pcm1_p1 <= '0;
      ir_p1   <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_p0   <= pc_nxt;
      pcm1_p1 <= pcm1_nxt;
      ir_p1   <= ir_nxt;
      vld_p1  <= vld_nxt;
    end
  end

  assign imem_addr = pc_p0;
  assign pc_value  = pc_p0;
  assign PC_minus1 = pcm1_p1;
  assign ir_out    = ir_p1;
  assign ir_valid  = vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic compared against a behavioural fetch model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [1:0]  bs;
  logic [7:0]  pc_next;
  logic [15:0] imem_data;
  logic [7:0]  imem_addr;
  logic [7:0]  pc_value;
  logic [7:0]  pc_minus1;
  logic [15:0] ir_out;
  logic        ir_valid;

  logic [15:0] rom [256];

  int checks;
  int errors;

  // Behavioural model: an instruction is fetched on every unstalled edge; it
  // is valid unless it was fetched in the same edge a redirect was taken.
  logic [7:0]  m_pc;
  logic [7:0]  m_pcm1;
  logic [15:0] m_ir;
  logic        m_valid;

  logic [40:0] got;
  logic [40:0] exp;

  fetch_unit #(.IW(16), .AW(8), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .BS        (bs),
    .pc_next   (pc_next),
    .imem_data (imem_data),
    .imem_addr (imem_addr),
    .pc_value  (pc_value),
    .PC_minus1 (pc_minus1),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid)
  );

  assign imem_data = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    if (rst) begin
      m_pc    = 8'h00;
      m_pcm1  = 8'h00;
      m_ir    = 16'h0000;
      m_valid = 1'b0;
    end else if (!stall) begin
      m_ir   = rom[m_pc];
      m_pcm1 = m_pc;
      if (m_valid && bs != 2'b00) begin
        m_pc    = pc_next;
        m_valid = 1'b0;
      end else begin
        m_pc    = m_pc + 8'd1;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; bs = 2'b00; pc_next = 8'h55;
    step();
    step();
    got = {pc_value, imem_addr, pc_minus1, ir_out, ir_valid};
    exp = {8'h00, 8'h00, 8'h00, 16'h0000, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", got, exp);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_ir [3];
    exp_ir[0] = 16'h1111; exp_ir[1] = 16'h2222; exp_ir[2] = 16'h3333;
    rst = 1'b0;
    bs = 2'b10; pc_next = 8'h77;
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL prime_invalid got %b expected 0", ir_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      bs = 2'b00;
      checks++;
      if (ir_out !== exp_ir[i] || pc_minus1 !== 8'(i) || ir_valid !== 1'b1
          || pc_value !== 8'(i + 1)) begin
        errors++;
        $display("FAIL seq_fetch%0d got ir=%h pcm1=%h v=%b pc=%h expected ir=%h pcm1=%h v=1 pc=%h",
                 i, ir_out, pc_minus1, ir_valid, pc_value, exp_ir[i], 8'(i), 8'(i + 1));
      end
    end
  endtask

  task automatic test_redirect();
    rst = 1'b1; step(); rst = 1'b0;
    step();
    step();
    checks++;
    if (ir_out !== 16'h2222 || pc_minus1 !== 8'h01) begin
      errors++;
      $display("FAIL redir_setup got ir=%h pcm1=%h expected ir=2222 pcm1=01", ir_out, pc_minus1);
    end
    bs = 2'b10; pc_next = 8'h40;
    step();
    bs = 2'b11; pc_next = 8'h99;
    checks++;
    if (ir_valid !== 1'b0 || pc_value !== 8'h40) begin
      errors++;
      $display("FAIL redir_bubble got v=%b pc=%h expected v=0 pc=40", ir_valid, pc_value);
    end
    step();
    bs = 2'b00;
    checks++;
    if (ir_out !== 16'hABCD || ir_valid !== 1'b1 || pc_minus1 !== 8'h40 || pc_value !== 8'h41) begin
      errors++;
      $display("FAIL redir_target got ir=%h v=%b pcm1=%h pc=%h expected ir=abcd v=1 pcm1=40 pc=41",
               ir_out, ir_valid, pc_minus1, pc_value);
    end
  endtask

  task automatic test_wrap();
    bs = 2'b10; pc_next = 8'hFE;
    step();
    bs = 2'b00;
    step();
    checks++;
    if (ir_out !== 16'hFEFE || pc_minus1 !== 8'hFE || pc_value !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_fe got ir=%h pcm1=%h pc=%h expected ir=fefe pcm1=fe pc=ff", ir_out, pc_minus1, pc_value);
    end
    step();
    checks++;
    if (ir_out !== 16'hFFFF || pc_minus1 !== 8'hFF || pc_value !== 8'h00) begin
      errors++;
      $display("FAIL wrap_ff got ir=%h pcm1=%h pc=%h expected ir=ffff pcm1=ff pc=00", ir_out, pc_minus1, pc_value);
    end
    step();
    checks++;
    if (ir_out !== 16'h1111 || pc_minus1 !== 8'h00 || ir_valid !== 1'b1 || pc_value !== 8'h01) begin
      errors++;
      $display("FAIL wrap_00 got ir=%h pcm1=%h v=%b pc=%h expected ir=1111 pcm1=00 v=1 pc=01",
               ir_out, pc_minus1, ir_valid, pc_value);
    end
  endtask

  task automatic test_stall_redirect();
    logic [40:0] frozen;
    step();
    frozen = {m_pc, m_pc, m_pcm1, m_ir, m_valid};
    stall = 1'b1; bs = 2'b10; pc_next = 8'h20;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {pc_value, imem_addr, pc_minus1, ir_out, ir_valid};
      checks++;
      if (got !== frozen) begin
        errors++;
        $display("FAIL stall_hold%0d got %h expected %h", i, got, frozen);
      end
    end
    stall = 1'b0;
    step();
    bs = 2'b00;
    checks++;
    if (pc_value !== 8'h20 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got pc=%h v=%b expected pc=20 v=0", pc_value, ir_valid);
    end
    step();
    checks++;
    if (ir_out !== 16'h2020 || pc_minus1 !== 8'h20 || ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_target got ir=%h pcm1=%h v=%b expected ir=2020 pcm1=20 v=1",
               ir_out, pc_minus1, ir_valid);
    end
  endtask

  task automatic test_reset_flush();
    bs = 2'b10; pc_next = 8'h30;
    step();
    bs = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (pc_value !== 8'h00 || ir_valid !== 1'b0 || ir_out !== 16'h0000 || pc_minus1 !== 8'h00) begin
      errors++;
      $display("FAIL flush_reset got pc=%h v=%b ir=%h pcm1=%h expected pc=00 v=0 ir=0000 pcm1=00",
               pc_value, ir_valid, ir_out, pc_minus1);
    end
    step();
    step();
    checks++;
    if (ir_out !== 16'h2222 || pc_minus1 !== 8'h01 || ir_valid !== 1'b1 || pc_value !== 8'h02) begin
      errors++;
      $display("FAIL flush_restart got ir=%h pcm1=%h v=%b pc=%h expected ir=2222 pcm1=01 v=1 pc=02",
               ir_out, pc_minus1, ir_valid, pc_value);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      rom[i] = r[15:0];
    end
    for (int i = 0; i < 500; i++) begin
      r = $urandom;
      rst     = (r[5:0] == 6'd0);
      stall   = (r[7:6] == 2'b00);
      bs      = r[9:8];
      pc_next = r[17:10];
      step();
      got = {pc_value, imem_addr, pc_minus1, ir_out, ir_valid};
      exp = {m_pc, m_pc, m_pcm1, m_ir, m_valid};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d got %h expected %h", i, got, exp);
      end
    end
    rst = 1'b0; stall = 1'b0; bs = 2'b00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; stall = 1'b0; bs = 2'b00; pc_next = 8'h00;
    m_pc = 8'h00; m_pcm1 = 8'h00; m_ir = 16'h0000; m_valid = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = {8'(i), 8'(i)};
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
    rom[8'h40] = 16'hABCD;

    test_reset();
    test_sequential();
    test_redirect();
    test_wrap();
    test_stall_redirect();
    test_reset_flush();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
